// File: rtl/vid_pkg.sv
// Shared video timing constants, FSM state type and source indices for the
// stream arbiter and the monitor timing block.
package vid_pkg;

  typedef enum logic {
    SEEK   = 1'b0,
    STREAM = 1'b1
  } vid_state_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic SRC_DMA = 1'b0;
  localparam logic SRC_TPG = 1'b1;

  // Counter width for n positions, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vid_frame_counter.sv
// Pixel/line position within the active frame; advances on each forwarded beat
// and raises start-of-frame, end-of-line and end-of-frame flags.
module vid_frame_counter
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  input  logic adv,
  output logic sof,
  output logic eol,
  output logic eof
);

  localparam int XW = cnt_w(H_ACTIVE);
  localparam int YW = cnt_w(V_ACTIVE);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  assign sof = (x_q == '0) && (y_q == '0);
  assign eol = (x_q == XW'(H_ACTIVE - 1));
  assign eof = eol && (y_q == YW'(V_ACTIVE - 1));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr) begin
      x_q <= '0;
      y_q <= '0;
    end else if (adv) begin
      if (eol) begin
        x_q <= '0;
        y_q <= eof ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

endmodule

// File: rtl/vid_src_arbiter.sv
// Frame-aligned 2:1 AXI4-Stream video arbiter: locks onto one source per frame,
// drains the other, and regenerates tuser/tlast from its own frame counters.
module vid_src_arbiter
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sel_i,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tuser,
  input  logic              s0_axis_tlast,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tuser,
  input  logic              s1_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              active_src_o,
  output logic              locked_o,
  output logic              frame_err_o
);

  vid_state_e        state_q, state_d;
  logic              active_src_q, active_src_d;
  logic              init_q, frame_err_q;
  logic              act_valid, act_user, act_last, act_ready;
  logic [DATA_W-1:0] act_data;
  logic              xfer, err, cnt_clr, sof, eol, eof;

  assign act_valid = (active_src_q == SRC_TPG) ? s1_axis_tvalid : s0_axis_tvalid;
  assign act_data  = (active_src_q == SRC_TPG) ? s1_axis_tdata  : s0_axis_tdata;
  assign act_user  = (active_src_q == SRC_TPG) ? s1_axis_tuser  : s0_axis_tuser;
  assign act_last  = (active_src_q == SRC_TPG) ? s1_axis_tlast  : s0_axis_tlast;

  // The inactive source is always drained so it never stalls upstream.
  assign s0_axis_tready = (active_src_q == SRC_DMA) ? act_ready : 1'b1;
  assign s1_axis_tready = (active_src_q == SRC_TPG) ? act_ready : 1'b1;

  assign xfer = m_axis_tvalid & m_axis_tready;
  assign err  = (state_q == STREAM) & xfer & ((act_user != sof) | (act_last != eol));

  vid_frame_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_cnt (
    .gclk  (clk_i),
    .grst_n(rst_ni),
    .clr   (cnt_clr),
    .adv   (xfer),
    .sof   (sof),
    .eol   (eol),
    .eof   (eof)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SEEK;
      active_src_q <= SRC_DMA;
      init_q       <= 1'b1;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_src_q <= active_src_d;
      init_q       <= 1'b0;
      frame_err_q  <= err;
    end
  end

  always_comb begin
    state_d      = state_q;
    active_src_d = active_src_q;
    cnt_clr      = 1'b0;
    // The first cycle out of reset only samples sel_i; nothing is forwarded.
    if (init_q) active_src_d = sel_i;
    case (state_q)
      SEEK: if (xfer) state_d = STREAM;
      STREAM: begin
        if (err) begin
          state_d      = SEEK;
          cnt_clr      = 1'b1;
          active_src_d = sel_i;
        end else if (xfer && eof && (sel_i != active_src_q)) begin
          state_d      = SEEK;
          active_src_d = sel_i;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // SEEK forwards only the tuser beat that opens a frame; STREAM is pass-through.
  always_comb begin
    m_axis_tvalid = 1'b0;
    act_ready     = 1'b1;
    case (state_q)
      SEEK: begin
        m_axis_tvalid = ~init_q & act_valid & act_user;
        if (m_axis_tvalid) act_ready = m_axis_tready;
      end
      STREAM: begin
        m_axis_tvalid = act_valid;
        act_ready     = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign m_axis_tdata = act_data;
  assign m_axis_tuser = sof;
  assign m_axis_tlast = eol;
  assign active_src_o = active_src_q;
  assign locked_o     = (state_q == STREAM);
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_vid_src_arbiter.sv
// Directed bench for vid_src_arbiter at 4x3 timing; expected beats go into a
// queue at drive time and a negedge monitor pops them on every m_axis transfer.
`timescale 1ns/1ps
module tb_vid_src_arbiter;

  localparam int H = 4;
  localparam int V = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic s0_tvalid = 1'b0, s0_tready, s0_tuser = 1'b0, s0_tlast = 1'b0;
  logic s1_tvalid = 1'b0, s1_tready, s1_tuser = 1'b0, s1_tlast = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0, m_tdata;
  logic m_tvalid, m_tready = 1'b1, m_tuser, m_tlast;
  logic active_src, locked, frame_err;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  bit stall_chk = 1'b0;
  bit s1_chk = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] held_data;
  logic [DW+1:0] exp_q[$];

  always #5 clk = ~clk;

  vid_src_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready), .s0_axis_tdata(s0_tdata),
    .s0_axis_tuser(s0_tuser), .s0_axis_tlast(s0_tlast),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready), .s1_axis_tdata(s1_tdata),
    .s1_axis_tuser(s1_tuser), .s1_axis_tlast(s1_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .active_src_o(active_src), .locked_o(locked), .frame_err_o(frame_err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, tready mirroring, drain of s1.
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (rst_n && m_tvalid && m_tready) begin
      xfer_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got %0h/%0b/%0b", m_tdata, m_tuser, m_tlast);
      end else begin
        e = exp_q.pop_front();
        if ({m_tdata, m_tuser, m_tlast} !== e) begin
          errors++;
          $display("FAIL beat got %0h/%0b/%0b exp %0h/%0b/%0b", m_tdata, m_tuser, m_tlast,
                   e[DW+1:2], e[1], e[0]);
        end
      end
    end
    if (stall_chk) begin
      if (prev_stall && m_tvalid) begin
        checks++;
        if (m_tdata !== held_data) begin
          errors++;
          $display("FAIL stall_data got %0h exp %0h", m_tdata, held_data);
        end
      end
      if (locked) begin
        checks++;
        if (s0_tready !== m_tready) begin
          errors++;
          $display("FAIL s0_tready_mirror got %0b exp %0b", s0_tready, m_tready);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      held_data  = m_tdata;
    end else begin
      prev_stall = 1'b0;
    end
    if (s1_chk) begin
      checks++;
      if (s1_tready !== 1'b1) begin
        errors++;
        $display("FAIL s1_drain got %0b exp 1", s1_tready);
      end
    end
  end

  // Drive one beat and hold it until accepted; optionally queue the expected output.
  task automatic send(input bit src, input logic [DW-1:0] d, input bit u, input bit l,
                      input bit push, input int idx);
    int n = 0;
    logic hs;
    if (src) begin
      s1_tvalid = 1'b1; s1_tdata = d; s1_tuser = u; s1_tlast = l;
    end else begin
      s0_tvalid = 1'b1; s0_tdata = d; s0_tuser = u; s0_tlast = l;
    end
    if (push) exp_q.push_back({d, idx == 0, (idx % H) == H - 1});
    forever begin
      @(negedge clk);
      hs = src ? (s1_tvalid && s1_tready) : (s0_tvalid && s0_tready);
      @(posedge clk);
      #1;
      if (hs) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout src %0d data %0h", src, d);
        break;
      end
    end
  endtask

  task automatic frame(input bit src, input logic [DW-1:0] base);
    for (int i = 0; i < H * V; i++) begin
      send(src, base + DW'(i), i == 0, (i % H) == H - 1, 1'b1, i);
      if (i == 0) chk("locked_after_sof", locked, 1);
    end
    if (src) s1_tvalid = 1'b0; else s0_tvalid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_active_src", active_src, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // 1: two stray beats dropped, then a clean frame locks.
    for (int j = 0; j < 2; j++) begin
      s0_tvalid = 1'b1; s0_tdata = 32'hF0 + DW'(j); s0_tuser = 1'b0; s0_tlast = 1'b0;
      @(negedge clk);
      chk("seek_s0_tready", s0_tready, 1);
      chk("seek_m_tvalid", m_tvalid, 0);
      chk("seek_locked", locked, 0);
      @(posedge clk); #1;
    end
    frame(1'b0, 32'h100);
    chk("t1_active_src", active_src, 0);

    // 2: sel changes mid-frame; switch happens at end of frame onto s1's next sof.
    fork
      begin
        for (int i = 0; i < H * V; i++) begin
          if (i == 4) sel = 1'b1;
          send(1'b0, 32'h110 + DW'(i), i == 0, (i % H) == H - 1, 1'b1, i);
        end
        s0_tvalid = 1'b0;
        @(negedge clk);
        chk("t2_switch_active", active_src, 1);
        chk("t2_switch_seek", locked, 0);
      end
      begin
        for (int f = 0; f < 4; f++)
          for (int i = 0; i < H * V; i++) begin
            if (f == 3 && i == 0) sel = 1'b0;
            send(1'b1, 32'h200 + DW'(i), i == 0, (i % H) == H - 1, f >= 1, i);
          end
        s1_tvalid = 1'b0;
      end
    join
    chk("t2_back_active", active_src, 0);
    chk("t2_back_seek", locked, 0);

    // 3: early tlast on beat 3 of the frame.
    for (int i = 0; i < H * V; i++) begin
      send(1'b0, 32'h300 + DW'(i), i == 0, (i == 2) || (i == 7) || (i == 11), i < 3, i);
      if (i == 1) chk("t3_no_err_yet", frame_err, 0);
      if (i == 2) begin
        chk("t3_err_pulse", frame_err, 1);
        chk("t3_err_seek", locked, 0);
      end
      if (i == 3) chk("t3_err_one_cycle", frame_err, 0);
    end
    frame(1'b0, 32'h310);

    // 4: backpressure 1,0,0,1.
    begin
      bit done = 1'b0;
      xfer_cnt  = 0;
      stall_chk = 1'b1;
      fork
        begin
          int k = 0;
          while (!done) begin
            m_tready = (k % 4 == 0) || (k % 4 == 3);
            k++;
            @(posedge clk); #1;
          end
          m_tready = 1'b1;
        end
        begin
          frame(1'b0, 32'h400);
          done = 1'b1;
        end
      join
      stall_chk = 1'b0;
      chk("t4_xfer_count", xfer_cnt, H * V);
    end

    // 5: asynchronous reset mid-frame.
    for (int i = 0; i < 7; i++) send(1'b0, 32'h500 + DW'(i), i == 0, (i % H) == H - 1, 1'b1, i);
    s0_tvalid = 1'b1; s0_tdata = 32'h507; s0_tuser = 1'b0; s0_tlast = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_m_tvalid", m_tvalid, 0);
    chk("t5_async_locked", locked, 0);
    s0_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send(1'b0, 32'h5F0, 1'b0, 1'b0, 1'b0, 1);
    send(1'b0, 32'h5F1, 1'b0, 1'b0, 1'b0, 2);
    chk("t5_still_seek", locked, 0);
    frame(1'b0, 32'h600);

    // 6: s1 streams while s0 is locked.
    s1_chk = 1'b1;
    fork
      frame(1'b0, 32'h700);
      begin
        for (int i = 0; i < H * V; i++)
          send(1'b1, 32'h800 + DW'(i), i == 0, (i % H) == H - 1, 1'b0, i);
        s1_tvalid = 1'b0;
      end
    join
    s1_chk = 1'b0;
    chk("t6_active_src", active_src, 0);

    repeat (3) begin @(posedge clk); #1; end
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/vid_src_arbiter.md
Name: vid_src_arbiter

Overview:
- Frame-aligned arbiter between two AXI4-Stream video sources (source 0 is the DMA reader, source 1 is the test-pattern generator) feeding the single stream input of the VGA output stage.
- Switches sources only on frame boundaries, so the VGA output stage always sees a whole frame that starts with tuser.
- Regenerates tuser/tlast from its own pixel/line counters and flags malformed input frames.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- DATA_W, 32, stream data width.

Ports:
- clk_i  in  1  pixel/stream clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- sel_i  in  1  requested source (0/1); sampled only at frame boundaries.
- s0_axis_tvalid/tready/tdata/tuser/tlast  in/out/in/in/in  1/1/DATA_W/1/1  source 0 stream.
- s1_axis_tvalid/tready/tdata/tuser/tlast  in/out/in/in/in  1/1/DATA_W/1/1  source 1 stream.
- m_axis_tvalid/tready/tdata/tuser/tlast  out/in/out/out/out  1/1/DATA_W/1/1  stream to the VGA output stage.
- active_src_o  out  1  source currently locked.
- locked_o  out  1  high while in STREAM.
- frame_err_o  out  1  one-cycle pulse on a detected framing error.

Behaviour:
Reset (rst_ni low, asynchronous):
- State SEEK, active_src_o=0, counters x=0 and y=0.
- locked_o=0, frame_err_o=0, m_axis_tvalid=0.
- First rising clk_i after deassertion loads active_src_o<=sel_i.

Handshakes and datapath:
- The non-active source always has tready=1: beats are drained and discarded so upstream never stalls.
- SEEK: active source tready=1, m_axis_tvalid=0. Beats are discarded until an accepted beat with tuser=1.
- That tuser beat is forwarded in the same cycle, not dropped:
  - It is presented combinationally on m_axis; the state stays SEEK until m_axis_tready.
  - While it is presented, active tready=m_axis_tready.
  - On acceptance the state goes to STREAM with x=1, y=0.
  - If H_ACTIVE=1 the accepted beat also completes line 0.
- STREAM: m_axis_tvalid=active tvalid, m_axis_tdata=active tdata, active tready=m_axis_tready. Zero-cycle pass-through, no added latency.
- m_axis_tuser=1 iff x==0 and y==0. m_axis_tlast=1 iff x==H_ACTIVE-1. Both are from counters; input tuser/tlast are checked but not forwarded.
- A transfer is m_axis_tvalid&m_axis_tready. On each transfer x increments. At x==H_ACTIVE-1, x wraps to 0 and y increments. At end of frame (x==H_ACTIVE-1, y==V_ACTIVE-1) y wraps to 0.

End of frame:
- If sel_i==active_src_o, stay in STREAM; the next beat is expected with tuser=1.
- Otherwise the next cycle has active_src_o<=sel_i and state SEEK.

Framing errors (checked on an accepted active beat in STREAM):
- Input tuser=1 with (x,y)!=(0,0).
- Input tlast differs from the counter tlast.
- Response to an error:
  - frame_err_o pulses for 1 cycle.
  - The offending beat is still forwarded.
  - State goes to SEEK, counters reset, active_src_o<=sel_i.
  - The VGA output stage resyncs through its own tuser detection.
- A tuser beat at (0,0) is legal. A missing tuser at (0,0) in STREAM is an error.

Other boundary rules:
- sel_i changes mid-frame are ignored until the end of the frame.
- Both sources valid in the same cycle: only the active source is forwarded, the other is drained.
- m_axis_tready low holds the counters; m_axis_tdata stays stable while the active source holds its beat.
- Reset mid-frame aborts at once; outputs go to their reset values asynchronously.

Counter widths: $clog2(H_ACTIVE) and $clog2(V_ACTIVE), with widths of at least 1.

Decomposition:
- Shared package vid_pkg:
  - state enum {SEEK, STREAM}.
  - Default H_ACTIVE/V_ACTIVE constants, shared with the monitor timing block.
  - Source index constants SRC_DMA=0, SRC_TPG=1.
- One natural sub-module: vid_frame_counter, holding the x/y counters, the wrap logic and the sof/eol/eof flags.
- The mux and FSM stay in the top.

Test Plan (bench uses H_ACTIVE=4, V_ACTIVE=3, m_axis_tready=1 unless stated):
1. Reset, then sel_i=0; s0 sends 2 non-tuser beats, then a clean 12-beat frame starting with tuser, data 0x100..0x10B.
   - Required: first 2 beats dropped with s0 tready=1.
   - m_axis carries 0x100..0x10B; tuser only on 0x100; tlast on beats 4/8/12.
   - locked_o=1 from the cycle after 0x100 is accepted.
2. Mid-frame sel_i 0->1 at beat 5, s1 streaming continuously.
   - Required: s0 frame finishes all 12 beats, then active_src_o=1 and state SEEK.
   - The first m_axis beat after the switch is s1's next tuser beat.
3. s0 asserts tlast at beat 3 instead of beat 4.
   - Required: frame_err_o high for exactly 1 cycle.
   - Beat 3 forwarded, then SEEK; the next s0 tuser frame locks cleanly.
4. Backpressure: m_axis_tready toggles 1,0,0,1 repeating during a frame.
   - Required: exactly 12 transfers, x/y frozen while tready=0.
   - m_axis_tdata stable during stalls; s0 tready mirrors m_axis_tready.
5. rst_ni pulled low asynchronously at beat 7.
   - Required: m_axis_tvalid=0 and locked_o=0 without waiting for a clock edge.
   - After release the block re-enters SEEK and relocks on the next tuser.
6. Inactive s1 streams continuously while s0 is locked.
   - Required: s1 tready=1 every cycle; no s1 data appears on m_axis.
